// File: rtl/zrb_uart_pkg.sv
// Shared definitions for the configurable UART: parity modes, FSM encoding
// and the divider width helper.
package zrb_uart_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4
  } state_e;

  // Divider counter width; clamped so a degenerate divider still yields 1 bit.
  function automatic int unsigned div_w(input int unsigned clk_div);
    return (clk_div < 2) ? 1 : $clog2(clk_div);
  endfunction

endpackage

// File: rtl/zrb_uart_bit_timer.sv
// Bit-time divider: counts 0..CLK_DIV-1 while enabled, strobes bit_end_c on
// the last count. Shared with the receiver.
module zrb_uart_bit_timer
  import zrb_uart_pkg::*;
#(
  parameter  int unsigned CLK_DIV = 434,
  localparam int unsigned CNT_W   = div_w(CLK_DIV)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             bit_end_c
);

  assign bit_end_c = en && (cnt == CNT_W'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= bit_end_c ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/zrb_uart_tx_cfg.sv
// Configurable UART transmitter: one-entry holding register, framing FSM,
// LSB-first shifter and optional parity, all outputs registered.
module zrb_uart_tx_cfg
  import zrb_uart_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 434,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = PAR_NONE,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  input  logic [DATA_BITS-1:0] in_data,
  output logic                 in_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int unsigned CNT_W = div_w(CLK_DIV);
  localparam int unsigned BIT_W = 4;

  if (CLK_DIV < 2) begin : g_bad_div
    $error("zrb_uart_tx_cfg: CLK_DIV must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
    $error("zrb_uart_tx_cfg: DATA_BITS must be 5..9");
  end
  if (PARITY > PAR_EVEN) begin : g_bad_par
    $error("zrb_uart_tx_cfg: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("zrb_uart_tx_cfg: STOP_BITS must be 1 or 2");
  end

  state_e               state, state_nx;
  logic                 hold_full, hold_full_nx;
  logic [DATA_BITS-1:0] hold_data;
  logic [DATA_BITS-1:0] shreg, shreg_nx;
  logic                 par_bit, par_nx, par_raw;
  logic [BIT_W-1:0]     bit_cnt, bit_cnt_nx;
  logic                 load;
  logic                 tx_nx, busy_nx, frame_done_nx;
  logic                 tmr_en, bit_end;
  logic [CNT_W-1:0]     div_cnt;

  assign tmr_en = (state != ST_IDLE);

  zrb_uart_bit_timer #(.CLK_DIV(CLK_DIV)) u_bit_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (tmr_en),
    .clr       (!tmr_en),
    .cnt       (div_cnt),
    .bit_end_c (bit_end)
  );

  // Next-state, shifter and registered-output decode
  always_comb begin
    state_nx   = state;
    shreg_nx   = shreg;
    par_nx     = par_bit;
    bit_cnt_nx = bit_cnt;
    load       = 1'b0;
    par_raw    = ^hold_data;

    case (state)
      ST_IDLE: begin
        if (hold_full) begin
          state_nx = ST_START;
          load     = 1'b1;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_nx   = ST_DATA;
          bit_cnt_nx = '0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shreg_nx = shreg >> 1;
          if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
            bit_cnt_nx = '0;
            state_nx   = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
          end else begin
            bit_cnt_nx = bit_cnt + BIT_W'(1);
          end
        end
      end
      ST_PAR: begin
        if (bit_end) begin
          state_nx   = ST_STOP;
          bit_cnt_nx = '0;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (bit_cnt == BIT_W'(STOP_BITS - 1)) begin
            bit_cnt_nx = '0;
            // A waiting character starts immediately: no idle bit between frames
            if (hold_full) begin
              state_nx = ST_START;
              load     = 1'b1;
            end else begin
              state_nx = ST_IDLE;
            end
          end else begin
            bit_cnt_nx = bit_cnt + BIT_W'(1);
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase

    if (load) begin
      shreg_nx = hold_data;
      par_nx   = (PARITY == PAR_ODD) ? ~par_raw : par_raw;
    end

    hold_full_nx = load ? 1'b0 : ((in_valid && in_ready) ? 1'b1 : hold_full);

    case (state_nx)
      ST_START: tx_nx = 1'b0;
      ST_DATA:  tx_nx = shreg_nx[0];
      ST_PAR:   tx_nx = par_nx;
      default:  tx_nx = 1'b1;
    endcase

    // Flag one cycle early so the registered pulse lands on the last stop cycle
    frame_done_nx = (state == ST_STOP) && (bit_cnt == BIT_W'(STOP_BITS - 1)) &&
                    (div_cnt == CNT_W'(CLK_DIV - 2));
    busy_nx       = (state_nx != ST_IDLE) || hold_full_nx;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      hold_full  <= 1'b0;
      hold_data  <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      bit_cnt    <= '0;
      tx         <= 1'b1;
      in_ready   <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nx;
      hold_full  <= hold_full_nx;
      shreg      <= shreg_nx;
      par_bit    <= par_nx;
      bit_cnt    <= bit_cnt_nx;
      tx         <= tx_nx;
      in_ready   <= !hold_full_nx;
      busy       <= busy_nx;
      frame_done <= frame_done_nx;
      if (in_valid && in_ready) begin
        hold_data <= in_data;
      end
    end
  end

endmodule

// File: tb/tb_zrb_uart_tx_cfg.sv
// Bench for zrb_uart_tx_cfg: several configurations side by side, each frame
// recovered by a sampling decoder and compared with a spec-level frame model.
module tb_zrb_uart_tx_cfg;

  localparam int NCFG = 8;

  function automatic int unsigned cfg_div(input int i);
    case (i)
      4:       return 2;
      5:       return 3;
      6:       return 16;
      7:       return 3;
      default: return 4;
    endcase
  endfunction

  function automatic int unsigned cfg_db(input int i);
    case (i)
      3:       return 7;
      5:       return 5;
      6:       return 9;
      7:       return 6;
      default: return 8;
    endcase
  endfunction

  function automatic int unsigned cfg_par(input int i);
    case (i)
      1, 5:    return 2;
      2, 4, 7: return 1;
      default: return 0;
    endcase
  endfunction

  function automatic int unsigned cfg_sb(input int i);
    case (i)
      2, 5, 6: return 2;
      default: return 1;
    endcase
  endfunction

  typedef struct {
    logic [12:0] raw;
    bit          stable;
    bit          fd_ok;
    bit          busy_ok;
    logic        rdy0;
    int          waited;
    bit          timeout;
  } rx_t;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [NCFG-1:0] in_valid;
  logic [NCFG-1:0] in_ready, tx, busy, frame_done;
  logic [8:0]      in_data [NCFG];
  logic [8:0]      exp_q [$];
  int              n_checks = 0;
  int              n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    localparam int unsigned DB = cfg_db(g);
    zrb_uart_tx_cfg #(
      .CLK_DIV   (cfg_div(g)),
      .DATA_BITS (DB),
      .PARITY    (cfg_par(g)),
      .STOP_BITS (cfg_sb(g))
    ) u_dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .in_valid   (in_valid[g]),
      .in_data    (in_data[g][DB-1:0]),
      .in_ready   (in_ready[g]),
      .tx         (tx[g]),
      .busy       (busy[g]),
      .frame_done (frame_done[g])
    );
  end

  // Expected line bits for one character, index 0 = start bit
  function automatic logic [12:0] exp_raw(input int i, input logic [8:0] d);
    logic [12:0] r;
    int db, ones, p;
    r    = '1;
    db   = int'(cfg_db(i));
    r[0] = 1'b0;
    ones = 0;
    for (int b = 0; b < db; b++) begin
      r[1+b] = d[b];
      ones  += int'(d[b]);
    end
    p = 1 + db;
    if (cfg_par(i) == 2) r[p] = (ones % 2 == 1);
    else if (cfg_par(i) == 1) r[p] = (ones % 2 == 0);
    return r;
  endfunction

  // Decoder: waits for a start bit, samples every cycle of the frame
  task automatic rx_frame(input int i, input int budget, output rx_t r);
    logic s [0:255];
    logic f [0:255];
    int div, nb, len;
    div = int'(cfg_div(i));
    nb  = 1 + int'(cfg_db(i)) + ((cfg_par(i) != 0) ? 1 : 0) + int'(cfg_sb(i));
    len = nb * div;
    r.raw = '1; r.stable = 1'b1; r.fd_ok = 1'b1; r.busy_ok = 1'b1;
    r.rdy0 = 1'b0; r.waited = 0; r.timeout = 1'b0;
    do begin
      @(negedge clk);
      r.waited++;
    end while (tx[i] !== 1'b0 && r.waited < budget);
    if (tx[i] !== 1'b0) begin
      r.timeout = 1'b1;
      return;
    end
    r.rdy0 = in_ready[i];
    for (int c = 0; c < len; c++) begin
      if (c > 0) @(negedge clk);
      s[c] = tx[i];
      f[c] = frame_done[i];
      if (busy[i] !== 1'b1) r.busy_ok = 1'b0;
    end
    for (int b = 0; b < nb; b++) begin
      r.raw[b] = s[b*div];
      for (int k = 1; k < div; k++)
        if (s[b*div+k] !== s[b*div]) r.stable = 1'b0;
    end
    for (int c = 0; c < len; c++)
      if (f[c] !== (c == len - 1)) r.fd_ok = 1'b0;
  endtask

  // Producer: optional gap, then hold valid until accepted
  task automatic send(input int i, input logic [8:0] d, input int gap);
    logic rdy;
    int n;
    if (gap > 0) begin
      in_valid[i] = 1'b0;
      in_data[i]  = 9'($urandom);
      repeat (gap) @(posedge clk);
      #1;
    end
    in_data[i]  = d;
    in_valid[i] = 1'b1;
    n = 0;
    forever begin
      rdy = in_ready[i];
      @(posedge clk);
      if (rdy === 1'b1) break;
      #1;
      n++;
      if (n > 2000) begin
        n_checks++; n_fail++;
        $display("FAIL accept_timeout cfg%0d: in_ready never rose for data %h", i, d);
        in_valid[i] = 1'b0;
        return;
      end
    end
    exp_q.push_back(d);
    @(negedge clk);
    in_valid[i] = 1'b0;
    in_data[i]  = 9'($urandom);
    n_checks++;
    if ({in_ready[i], busy[i]} !== 2'b01) begin
      n_fail++;
      $display("FAIL ready_drop cfg%0d: {in_ready,busy} got %b want 01", i, {in_ready[i], busy[i]});
    end
  endtask

  task automatic single_frame(input int i, input logic [8:0] d, output rx_t r);
    rx_t rr;
    @(negedge clk);
    fork
      send(i, d, 0);
      rx_frame(i, 400, rr);
    join
    r = rr;
  endtask

  task automatic test_reset();
    logic [NCFG-1:0] ones;
    ones = '1;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (tx !== ones) begin n_fail++; $display("FAIL reset_tx: got %b want %b", tx, ones); end
    n_checks++;
    if (in_ready !== ones) begin n_fail++; $display("FAIL reset_ready: got %b want %b", in_ready, ones); end
    n_checks++;
    if (busy !== '0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++;
    if (frame_done !== '0) begin n_fail++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
  endtask

  task automatic test_latency();
    rx_t r;
    single_frame(0, 9'h3C, r);
    n_checks++;
    if (r.waited !== 2) begin n_fail++; $display("FAIL start_latency: got %0d negedges want 2", r.waited); end
    n_checks++;
    if (r.raw !== exp_raw(0, 9'h3C)) begin n_fail++; $display("FAIL latency_frame: got %b want %b", r.raw, exp_raw(0, 9'h3C)); end
    @(negedge clk);
    n_checks++;
    if ({tx[0], busy[0], in_ready[0]} !== 3'b101) begin
      n_fail++; $display("FAIL latency_idle: {tx,busy,ready} got %b want 101", {tx[0], busy[0], in_ready[0]});
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid_frame();
    rx_t r;
    @(negedge clk);
    send(0, 9'h55, 0);
    repeat (8) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({tx[0], in_ready[0], busy[0], frame_done[0]} !== 4'b1100) begin
      n_fail++; $display("FAIL reset_mid: {tx,ready,busy,fd} got %b want 1100", {tx[0], in_ready[0], busy[0], frame_done[0]});
    end
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    single_frame(0, 9'h55, r);
    n_checks++;
    if (r.raw !== exp_raw(0, 9'h55)) begin n_fail++; $display("FAIL post_reset_frame: got %b want %b", r.raw, exp_raw(0, 9'h55)); end
    n_checks++;
    if ({r.timeout, r.stable, r.fd_ok, r.busy_ok, r.rdy0} !== 5'b01111) begin
      n_fail++; $display("FAIL post_reset_shape: got %b want 01111", {r.timeout, r.stable, r.fd_ok, r.busy_ok, r.rdy0});
    end
    exp_q.delete();
  endtask

  task automatic test_even_parity();
    rx_t r;
    logic [10:0] seq;
    seq = 11'b1_0_10100101_0;
    single_frame(1, 9'h0A5, r);
    n_checks++;
    if (r.raw[10:0] !== seq) begin n_fail++; $display("FAIL even_par_seq: got %b want %b", r.raw[10:0], seq); end
    n_checks++;
    if ({r.timeout, r.stable, r.fd_ok, r.busy_ok, r.rdy0} !== 5'b01111) begin
      n_fail++; $display("FAIL even_par_shape: got %b want 01111", {r.timeout, r.stable, r.fd_ok, r.busy_ok, r.rdy0});
    end
    @(negedge clk);
    n_checks++;
    if ({tx[1], busy[1]} !== 2'b10) begin n_fail++; $display("FAIL even_par_idle: {tx,busy} got %b want 10", {tx[1], busy[1]}); end
    exp_q.delete();
  endtask

  task automatic test_odd_two_stop();
    rx_t r;
    single_frame(2, 9'h000, r);
    n_checks++;
    if (r.raw !== exp_raw(2, 9'h000)) begin n_fail++; $display("FAIL odd_2stop_frame: got %b want %b", r.raw, exp_raw(2, 9'h000)); end
    n_checks++;
    if (r.raw[9] !== 1'b1) begin n_fail++; $display("FAIL odd_par_bit: got %b want 1", r.raw[9]); end
    n_checks++;
    if ({r.timeout, r.stable, r.fd_ok, r.busy_ok, r.rdy0} !== 5'b01111) begin
      n_fail++; $display("FAIL odd_2stop_shape: got %b want 01111", {r.timeout, r.stable, r.fd_ok, r.busy_ok, r.rdy0});
    end
    @(negedge clk);
    n_checks++;
    if ({tx[2], busy[2]} !== 2'b10) begin n_fail++; $display("FAIL odd_2stop_idle: {tx,busy} got %b want 10", {tx[2], busy[2]}); end
    exp_q.delete();
  endtask

  task automatic test_7bit();
    rx_t r;
    single_frame(3, 9'h041, r);
    n_checks++;
    if (r.raw !== exp_raw(3, 9'h041)) begin n_fail++; $display("FAIL 7bit_frame: got %b want %b", r.raw, exp_raw(3, 9'h041)); end
    n_checks++;
    if ({r.timeout, r.stable, r.fd_ok, r.busy_ok, r.rdy0} !== 5'b01111) begin
      n_fail++; $display("FAIL 7bit_shape: got %b want 01111", {r.timeout, r.stable, r.fd_ok, r.busy_ok, r.rdy0});
    end
    @(negedge clk);
    n_checks++;
    if ({tx[3], busy[3]} !== 2'b10) begin n_fail++; $display("FAIL 7bit_idle: {tx,busy} got %b want 10", {tx[3], busy[3]}); end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    rx_t r [3];
    @(negedge clk);
    fork
      begin
        for (int k = 1; k <= 3; k++) send(0, 9'(k), 0);
      end
      begin
        for (int k = 0; k < 3; k++) rx_frame(0, 400, r[k]);
      end
    join
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (r[k].raw !== exp_raw(0, 9'(k + 1))) begin
        n_fail++; $display("FAIL b2b_frame%0d: got %b want %b", k, r[k].raw, exp_raw(0, 9'(k + 1)));
      end
      n_checks++;
      if ({r[k].timeout, r[k].stable, r[k].fd_ok, r[k].busy_ok, r[k].rdy0} !== 5'b01111) begin
        n_fail++; $display("FAIL b2b_shape%0d: got %b want 01111", k, {r[k].timeout, r[k].stable, r[k].fd_ok, r[k].busy_ok, r[k].rdy0});
      end
      if (k > 0) begin
        n_checks++;
        if (r[k].waited !== 1) begin n_fail++; $display("FAIL b2b_gap%0d: got %0d idle cycles want 0", k, r[k].waited - 1); end
      end
    end
    exp_q.delete();
  endtask

  task automatic test_random();
    for (int i = 0; i < NCFG; i++) begin
      logic [8:0] mask;
      mask = 9'((1 << cfg_db(i)) - 1);
      exp_q.delete();
      @(negedge clk);
      fork
        begin
          for (int k = 0; k < 6; k++) begin
            int gap;
            gap = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 40));
            send(i, 9'($urandom) & mask, gap);
          end
        end
        begin
          for (int k = 0; k < 6; k++) begin
            rx_t r;
            logic [8:0] d;
            rx_frame(i, 3000, r);
            n_checks++;
            if ({r.timeout, r.stable, r.fd_ok, r.busy_ok, r.rdy0} !== 5'b01111) begin
              n_fail++; $display("FAIL rand_shape cfg%0d #%0d: got %b want 01111", i, k, {r.timeout, r.stable, r.fd_ok, r.busy_ok, r.rdy0});
            end
            n_checks++;
            if (exp_q.size() == 0) begin
              n_fail++; $display("FAIL rand_order cfg%0d #%0d: frame seen with nothing accepted", i, k);
            end else begin
              d = exp_q.pop_front();
              if (r.raw !== exp_raw(i, d)) begin
                n_fail++; $display("FAIL rand_frame cfg%0d #%0d: got %b want %b (data %h)", i, k, r.raw, exp_raw(i, d), d);
              end
            end
          end
        end
      join
      @(negedge clk);
      n_checks++;
      if ({tx[i], busy[i], in_ready[i]} !== 3'b101) begin
        n_fail++; $display("FAIL rand_idle cfg%0d: {tx,busy,ready} got %b want 101", i, {tx[i], busy[i], in_ready[i]});
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n  = 1'b0;
    in_valid = '0;
    for (int i = 0; i < NCFG; i++) in_data[i] = '0;
    test_reset();
    test_latency();
    test_reset_mid_frame();
    test_even_parity();
    test_odd_two_stop();
    test_7bit();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
